// File: rtl/acp_read_arbiter_if.sv
// AXI3-style read path bundle (AR + R channels without RLAST/RID).
// master drives requests and rready; slave answers with arready, rvalid and rdata.
interface acp_read_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 64,
   parameter int LEN_W  = 4
);
   logic              arvalid;
   logic              arready;
   logic [ADDR_W-1:0] araddr;
   logic [LEN_W-1:0]  arlen;
   logic              rvalid;
   logic              rready;
   logic [DATA_W-1:0] rdata;

   modport master (
      output arvalid, araddr, arlen, rready,
      input  arready, rvalid, rdata
   );

   modport slave (
      input  arvalid, araddr, arlen, rready,
      output arready, rvalid, rdata
   );
endinterface

// File: rtl/acp_read_arbiter.sv
// Round-robin arbiter sharing one ACP read path between two requesters, one burst in flight.
// Define ACP_ARB_PERF_EN to add grant and stall performance counters.
module acp_read_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 64,
   parameter int LEN_W  = 4
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   acp_read_arbiter_if.slave   s0,
   acp_read_arbiter_if.slave   s1,
   acp_read_arbiter_if.master  m,
   output logic                o_busy,
   output logic                o_grant_id
`ifdef ACP_ARB_PERF_EN
   ,
   output logic [31:0]         o_perf_grants0,
   output logic [31:0]         o_perf_grants1,
   output logic [31:0]         o_perf_stall
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_next;
   logic              r_arvalid;
   logic [ADDR_W-1:0] r_araddr;
   logic [LEN_W-1:0]  r_arlen;
   logic [LEN_W-1:0]  r_cnt;
   logic              r_grant;
   logic              r_ptr;

   logic              w_any_req;
   logic              w_pick;
   logic              w_ar_hs;
   logic              w_gnt_rready;
   logic              w_r_hs;
   logic              w_last;
   logic [DATA_W-1:0] w_rdata;

   // Pointer only breaks ties; a lone requester wins regardless of it.
   assign w_any_req    = s0.arvalid | s1.arvalid;
   assign w_pick       = (s0.arvalid & s1.arvalid) ? r_ptr : s1.arvalid;
   assign w_ar_hs      = (r_state == ST_ADDR) & m.arready;
   assign w_gnt_rready = r_grant ? s1.rready : s0.rready;
   assign w_r_hs       = (r_state == ST_DATA) & m.rvalid & w_gnt_rready;
   assign w_last       = w_r_hs & (r_cnt == '0);

   assign m.arvalid  = r_arvalid;
   assign m.araddr   = r_araddr;
   assign m.arlen    = r_arlen;
   assign w_rdata    = m.rdata;
   assign s0.rdata   = w_rdata;
   assign s1.rdata   = w_rdata;
   assign o_busy     = (r_state != ST_IDLE);
   assign o_grant_id = r_grant;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      s0.arready   = 1'b0;
      s1.arready   = 1'b0;
      s0.rvalid    = 1'b0;
      s1.rvalid    = 1'b0;
      m.rready     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_any_req) begin
               w_state_next = ST_ADDR;
            end
         end
         ST_ADDR: begin
            s0.arready = m.arready & ~r_grant;
            s1.arready = m.arready &  r_grant;
            if (w_ar_hs) begin
               w_state_next = ST_DATA;
            end
         end
         ST_DATA: begin
            m.rready  = w_gnt_rready;
            s0.rvalid = m.rvalid & ~r_grant;
            s1.rvalid = m.rvalid &  r_grant;
            if (w_last) begin
               w_state_next = ST_IDLE;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // Request fields are latched at grant time; the requester's later values are ignored.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_arvalid <= 1'b0;
         r_araddr  <= '0;
         r_arlen   <= '0;
         r_cnt     <= '0;
         r_grant   <= 1'b0;
         r_ptr     <= 1'b0;
      end else begin
         if ((r_state == ST_IDLE) && w_any_req) begin
            r_arvalid <= 1'b1;
            r_grant   <= w_pick;
            r_araddr  <= w_pick ? s1.araddr : s0.araddr;
            r_arlen   <= w_pick ? s1.arlen  : s0.arlen;
         end
         if (w_ar_hs) begin
            r_arvalid <= 1'b0;
            r_cnt     <= r_arlen;
         end
         if (w_r_hs && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
         end
         if (w_last) begin
            r_ptr <= ~r_grant;
         end
      end
   end

`ifdef ACP_ARB_PERF_EN
   logic [31:0] r_perf_grants0;
   logic [31:0] r_perf_grants1;
   logic [31:0] r_perf_stall;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_perf_grants0 <= '0;
         r_perf_grants1 <= '0;
         r_perf_stall   <= '0;
      end else begin
         if (w_ar_hs && !r_grant) r_perf_grants0 <= r_perf_grants0 + 32'd1;
         if (w_ar_hs &&  r_grant) r_perf_grants1 <= r_perf_grants1 + 32'd1;
         if ((r_state == ST_DATA) && m.rvalid && !w_gnt_rready) begin
            r_perf_stall <= r_perf_stall + 32'd1;
         end
      end
   end

   assign o_perf_grants0 = r_perf_grants0;
   assign o_perf_grants1 = r_perf_grants1;
   assign o_perf_stall   = r_perf_stall;
`endif

endmodule
